// File: rtl/barrier_coordinator_if.sv
// Ring-side signals of the barrier coordinator: incoming slot fields, outgoing slot fields,
// and the token request/grant pair.
interface barrier_coordinator_if;
    logic [31:0] ring_in;
    logic [3:0]  slot_type_in;
    logic [3:0]  source_in;
    logic [31:0] ring_out;
    logic [3:0]  slot_type_out;
    logic [3:0]  source_out;
    logic        drive_ring;
    logic        wants_token;
    logic        acquire_token;

    // Token handshake: wants_token is held high while a release is pending; the cycle in
    // which acquire_token is also high is the single cycle the coordinator drives the ring.
    modport slave (
        input  ring_in, slot_type_in, source_in, acquire_token,
        output ring_out, slot_type_out, source_out, drive_ring, wants_token
    );

    modport master (
        output ring_in, slot_type_in, source_in, acquire_token,
        input  ring_out, slot_type_out, source_out, drive_ring, wants_token
    );
endinterface

// File: rtl/barrier_coordinator.sv
// Central barrier responder: gathers Arrive slots into a per-core mask and, once every
// expected core has arrived, takes the ring token to broadcast one Release with the generation.
module barrier_coordinator #(
    parameter logic [3:0] SLOT_ARRIVE  = 4'd8,
    parameter logic [3:0] SLOT_RELEASE = 4'd9,
    parameter int         GEN_W        = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [3:0]           which_core_i,
    input  logic [15:0]          expected_mask_i,
    input  logic                 clear_errors_i,
    barrier_coordinator_if.slave ring,
    output logic [GEN_W-1:0]     generation_o,
    output logic [15:0]          arrived_mask_o,
    output logic                 busy_o,
    output logic                 dup_error_o,
    output logic                 stray_error_o,
    output logic                 overrun_error_o,
    output logic [0:0]           state_o
);

    localparam logic [0:0] ST_COLLECT    = 1'b0;
    localparam logic [0:0] ST_WAIT_TOKEN = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [15:0]      arrived_q, arrived_d;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic             dup_q, dup_d;
    logic             stray_q, stray_d;
    logic             overrun_q, overrun_d;

    logic        arrive, stray_ev, dup_ev, accept, complete;
    logic        waiting, release_now, overrun_ev;
    logic [15:0] src_bit, next_mask;

    // The arrival payload carries nothing the coordinator needs.
    logic unused_ring;
    assign unused_ring = ^ring.ring_in;

    always_comb begin
        src_bit   = 16'b1 << ring.source_in;
        arrive    = (ring.slot_type_in == SLOT_ARRIVE);
        stray_ev  = arrive && ((src_bit & expected_mask_i) == 16'b0);
        dup_ev    = arrive && !stray_ev && ((src_bit & arrived_q) != 16'b0);
        accept    = arrive && !stray_ev && !dup_ev;
        next_mask = arrived_q | src_bit;
        complete  = accept && (expected_mask_i != 16'b0) && (next_mask == expected_mask_i);
    end

    // Reset masks the token outputs immediately, before the state register clears.
    assign waiting     = (state_q == ST_WAIT_TOKEN) && !rst_i;
    assign release_now = waiting && ring.acquire_token;

    always_comb begin
        state_d    = state_q;
        gen_d      = gen_q;
        overrun_ev = 1'b0;
        arrived_d  = arrived_q;
        if (complete) begin
            arrived_d = 16'b0;
        end else if (accept) begin
            arrived_d = next_mask;
        end
        case (state_q)
            ST_COLLECT: begin
                if (complete) begin
                    state_d = ST_WAIT_TOKEN;
                end
            end
            ST_WAIT_TOKEN: begin
                // A completion in the grant cycle belongs to the generation after this release.
                if (release_now) begin
                    gen_d   = gen_q + 1'b1;
                    state_d = complete ? ST_WAIT_TOKEN : ST_COLLECT;
                end else if (complete) begin
                    overrun_ev = 1'b1;
                end
            end
            default: state_d = ST_COLLECT;
        endcase
        dup_d     = dup_ev     | (dup_q     & ~clear_errors_i);
        stray_d   = stray_ev   | (stray_q   & ~clear_errors_i);
        overrun_d = overrun_ev | (overrun_q & ~clear_errors_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_COLLECT;
            arrived_q <= 16'b0;
            gen_q     <= '0;
            dup_q     <= 1'b0;
            stray_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            arrived_q <= arrived_d;
            gen_q     <= gen_d;
            dup_q     <= dup_d;
            stray_q   <= stray_d;
            overrun_q <= overrun_d;
        end
    end

    assign ring.wants_token   = waiting;
    assign ring.drive_ring    = release_now;
    assign ring.ring_out      = release_now ? 32'(gen_q) : 32'b0;
    assign ring.slot_type_out = release_now ? SLOT_RELEASE : 4'b0;
    assign ring.source_out    = release_now ? which_core_i : 4'b0;

    assign generation_o    = gen_q;
    assign arrived_mask_o  = arrived_q;
    assign busy_o          = (state_q == ST_WAIT_TOKEN);
    assign dup_error_o     = dup_q;
    assign stray_error_o   = stray_q;
    assign overrun_error_o = overrun_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_barrier_coordinator.sv
// Randomized and directed checks of barrier_coordinator against a set-based barrier model.
module tb_barrier_coordinator;

  localparam int GEN_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       which_core;
  logic [15:0]      expected_mask;
  logic             clear_errors;
  logic [GEN_W-1:0] generation;
  logic [15:0]      arrived_mask;
  logic             busy, dup_error, stray_error, overrun_error;
  logic [0:0]       state;

  barrier_coordinator_if bus ();

  barrier_coordinator #(.SLOT_ARRIVE(4'd8), .SLOT_RELEASE(4'd9), .GEN_W(GEN_W)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .which_core_i    (which_core),
    .expected_mask_i (expected_mask),
    .clear_errors_i  (clear_errors),
    .ring            (bus.slave),
    .generation_o    (generation),
    .arrived_mask_o  (arrived_mask),
    .busy_o          (busy),
    .dup_error_o     (dup_error),
    .stray_error_o   (stray_error),
    .overrun_error_o (overrun_error),
    .state_o         (state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Barrier viewed as a set of arrived cores, a pending-release flag and a release count.
  bit arrived_set[16];
  bit m_pending;
  int m_releases;
  bit m_dup, m_stray, m_over;
  bit cmp_en = 0;

  function automatic logic [15:0] model_mask();
    logic [15:0] m = '0;
    for (int i = 0; i < 16; i++) m[i] = arrived_set[i];
    return m;
  endfunction

  function automatic bit all_expected_in();
    for (int i = 0; i < 16; i++)
      if (expected_mask[i] && !arrived_set[i]) return 0;
    return (expected_mask != 0);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      foreach (arrived_set[i]) arrived_set[i] = 0;
      m_pending = 0; m_releases = 0; m_dup = 0; m_stray = 0; m_over = 0;
    end else begin
      bit completed, released;
      int src;
      completed = 0;
      released  = m_pending && bus.acquire_token;
      src       = int'(bus.source_in);
      if (clear_errors) begin m_dup = 0; m_stray = 0; m_over = 0; end
      if (bus.slot_type_in == 4'd8) begin
        if (!expected_mask[src]) m_stray = 1;
        else if (arrived_set[src]) m_dup = 1;
        else begin
          arrived_set[src] = 1;
          if (all_expected_in()) begin
            completed = 1;
            foreach (arrived_set[i]) arrived_set[i] = 0;
          end
        end
      end
      if (released) m_releases++;
      if (completed) begin
        if (m_pending && !released) m_over = 1;
        m_pending = 1;
      end else if (released) begin
        m_pending = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      logic exp_drive;
      logic [7:0] gen_mod;
      gen_mod   = 8'(m_releases % 256);
      exp_drive = m_pending && !rst && bus.acquire_token;
      check("wants_token", {31'b0, bus.wants_token}, {31'b0, m_pending && !rst});
      check("drive_ring", {31'b0, bus.drive_ring}, {31'b0, exp_drive});
      check("ring_out", bus.ring_out, exp_drive ? {24'b0, gen_mod} : 32'b0);
      check("slot_type_out", {28'b0, bus.slot_type_out}, exp_drive ? 32'd9 : 32'd0);
      check("source_out", {28'b0, bus.source_out}, exp_drive ? {28'b0, which_core} : 32'd0);
      check("generation", {24'b0, generation}, {24'b0, gen_mod});
      check("arrived_mask", {16'b0, arrived_mask}, {16'b0, model_mask()});
      check("busy", {31'b0, busy}, {31'b0, m_pending});
      check("dup_error", {31'b0, dup_error}, {31'b0, m_dup});
      check("stray_error", {31'b0, stray_error}, {31'b0, m_stray});
      check("overrun_error", {31'b0, overrun_error}, {31'b0, m_over});
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the active edge and hold for the whole cycle.
  task automatic step(input logic [3:0] st, input logic [3:0] src, input logic acq,
                      input logic clr);
    @(posedge clk); #1;
    bus.slot_type_in  = st;
    bus.source_in     = src;
    bus.ring_in       = $urandom;
    bus.acquire_token = acq;
    clear_errors      = clr;
  endtask

  task automatic arrive(input logic [3:0] src);
    step(4'd8, src, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic acq);
    step(4'd0, 4'd0, acq, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.slot_type_in = 4'd0; bus.acquire_token = 1'b0; clear_errors = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  int releases_seen;

  initial begin
    rst = 1'b1;
    which_core = 4'hA;
    expected_mask = 16'h003C;
    clear_errors = 1'b0;
    bus.ring_in = '0; bus.slot_type_in = '0; bus.source_in = '0; bus.acquire_token = 1'b0;
    @(posedge clk); #1;
    cmp_en = 1;
    sample();
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_generation", {24'b0, generation}, 32'd0);
    check("reset_arrived", {16'b0, arrived_mask}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: four arrivals complete, grant gives one release with generation 0
    arrive(4'd2); arrive(4'd3); arrive(4'd4); arrive(4'd5);
    sample();
    check("t1_busy_on_last_arrive", {31'b0, busy}, 32'd0);
    idle(1'b1); sample();
    check("t1_busy", {31'b0, busy}, 32'd1);
    check("t1_drive", {31'b0, bus.drive_ring}, 32'd1);
    check("t1_slot", {28'b0, bus.slot_type_out}, 32'd9);
    check("t1_source", {28'b0, bus.source_out}, 32'hA);
    check("t1_ring", bus.ring_out, 32'd0);
    idle(1'b1); sample();
    check("t1_gen", {24'b0, generation}, 32'd1);
    check("t1_no_second_release", {31'b0, bus.drive_ring}, 32'd0);

    // 2: duplicate arrival
    expected_mask = 16'h0006;
    arrive(4'd1); arrive(4'd1); idle(1'b0); sample();
    check("t2_dup", {31'b0, dup_error}, 32'd1);
    check("t2_mask", {16'b0, arrived_mask}, 32'h0002);
    check("t2_no_release", {31'b0, bus.wants_token}, 32'd0);
    arrive(4'd2); idle(1'b1); sample();
    check("t2_release", {31'b0, bus.drive_ring}, 32'd1);
    check("t2_ring", bus.ring_out, 32'd1);
    step(4'd0, 4'd0, 1'b0, 1'b1);

    // 3: stray arrival and clear
    arrive(4'd7); idle(1'b0); sample();
    check("t3_stray", {31'b0, stray_error}, 32'd1);
    check("t3_mask", {16'b0, arrived_mask}, 32'd0);
    step(4'd0, 4'd0, 1'b0, 1'b1); idle(1'b0); sample();
    check("t3_cleared", {31'b0, stray_error}, 32'd0);

    // 4: long token wait with next-generation arrival
    arrive(4'd1); arrive(4'd2);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) arrive(4'd1); else idle(1'b0);
      sample();
      check("t4_wants", {31'b0, bus.wants_token}, 32'd1);
      check("t4_nodrive", {31'b0, bus.drive_ring}, 32'd0);
    end
    check("t4_mask_wait", {16'b0, arrived_mask}, 32'h0002);
    idle(1'b1); sample();
    check("t4_release", {31'b0, bus.drive_ring}, 32'd1);
    idle(1'b0); sample();
    check("t4_mask_after", {16'b0, arrived_mask}, 32'h0002);
    check("t4_gen", {24'b0, generation}, 32'd3);

    // 6: reset while waiting for the token
    arrive(4'd2); arrive(4'd1);
    @(posedge clk); #1;
    rst = 1'b1; bus.slot_type_in = 4'd0; bus.acquire_token = 1'b1;
    sample();
    check("t6_drive_in_reset", {31'b0, bus.drive_ring}, 32'd0);
    @(posedge clk); #1;
    sample();
    check("t6_wants", {31'b0, bus.wants_token}, 32'd0);
    check("t6_gen", {24'b0, generation}, 32'd0);
    check("t6_mask", {16'b0, arrived_mask}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1'b1); sample();
    check("t6_never_driven", {31'b0, bus.drive_ring}, 32'd0);

    // 5: 256 single-core barriers wrap the generation
    expected_mask = 16'h0001;
    releases_seen = 0;
    for (int i = 0; i < 256; i++) begin
      arrive(4'd0);
      idle(1'b1); sample();
      if (bus.drive_ring) releases_seen++;
      if (i == 255) check("t5_ring_255", bus.ring_out, 32'd255);
    end
    idle(1'b0); sample();
    check("t5_releases", releases_seen, 32'd256);
    check("t5_wrap", {24'b0, generation}, 32'd0);

    // Randomized traffic checked by the model every cycle
    for (int cyc = 0; cyc < 4000; cyc++) begin
      logic [3:0] st, src;
      if (model_mask() == 0 && !m_pending && $urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 5))
          0: expected_mask = 16'h0003;
          1: expected_mask = 16'h8001;
          2: expected_mask = 16'h0F00;
          3: expected_mask = 16'h0000;
          4: expected_mask = 16'($urandom) & 16'h1248;
          default: expected_mask = 16'h0010;
        endcase
        which_core = 4'($urandom);
      end
      st  = ($urandom_range(0, 9) < 5) ? 4'd8 : 4'($urandom);
      src = 4'($urandom);
      if (expected_mask != 0 && $urandom_range(0, 3) != 0)
        for (int t = 0; t < 32 && !expected_mask[src]; t++) src = 4'($urandom);
      step(st, src, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 599) == 0) begin
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
      end
    end

    idle(1'b0);
    @(posedge clk); #1;
    cmp_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
